// File: rtl/nn_pkg.sv
// Shared neural-layer definitions: default data formats
// and the MAC writer state encoding.
package nn_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_FRAC   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_mac_writer_relu_sat.sv
// Activation: rescale accumulator to DATA_W fixed point,
// then ReLU with positive saturation.
module relu_sat
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [ACC_W-1:0]  x,
    output logic        [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] MAX =
        ACC_W'((1 << (DATA_W - 1)) - 1);

    logic signed [ACC_W-1:0] shifted;

    // Shift out the extra fraction bits, then clamp to [0, MAX]
    always_comb begin
        shifted = x >>> FRAC;
        y       = '0;
        if (shifted < 0) begin
            y = '0;
        end else if (shifted > MAX) begin
            y = MAX[DATA_W-1:0];
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_writer.sv
// Multiply-accumulate over a neuron's inputs and write the
// activated result back to neuron memory, one neuron at a time.
module neuron_mac_writer
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              neuron_finished,
    input  logic              finished,
    input  logic [7:0]        neuro_write_addr,
    input  logic [DATA_W-1:0] weight_data,
    input  logic [DATA_W-1:0] neuro_data,
    output logic              wr_en,
    output logic [7:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_t state, state_nx;

    logic                      valid_d;
    logic                      last_d;
    logic                      final_d;
    logic [7:0]                waddr_d;
    logic                      wr_final;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] x_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]         act;
    logic                      abort;
    logic                      capture;
    logic                      commit;

    assign w_ext = {{DATA_W{weight_data[DATA_W-1]}}, weight_data};
    assign x_ext = {{DATA_W{neuro_data[DATA_W-1]}}, neuro_data};
    assign prod  = w_ext * x_ext;

    assign acc_next =
        acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // A restart while active throws away the partial neuron
    assign abort   = start && (state == RUN || state == DRAIN);
    assign capture = (state == RUN) && !start;
    assign commit  = valid_d && last_d && !abort;

    relu_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .FRAC   (FRAC)
    ) u_act (
        .x (acc_next),
        .y (act)
    );

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN: begin
                if (start)         state_nx = RUN;
                else if (finished) state_nx = DRAIN;
            end
            DRAIN: begin
                if (start)                  state_nx = RUN;
                else if (wr_en && wr_final) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Delay address-side flags by one cycle to line up with read data;
    // a lone 'finished' also closes the current neuron
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d <= 1'b0;
            last_d  <= 1'b0;
            final_d <= 1'b0;
            waddr_d <= '0;
        end else if (capture) begin
            valid_d <= 1'b1;
            last_d  <= neuron_finished | finished;
            final_d <= finished;
            waddr_d <= neuro_write_addr;
        end else begin
            valid_d <= 1'b0;
            last_d  <= 1'b0;
            final_d <= 1'b0;
            waddr_d <= '0;
        end
    end

    // Accumulator restarts from zero right after each neuron's last product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            acc <= '0;
        else if (abort)        acc <= '0;
        else if (commit)       acc <= '0;
        else if (valid_d)      acc <= acc_next;
    end

    // Write port: one strobe per completed neuron
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en    <= 1'b0;
            wr_final <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en    <= commit;
            wr_final <= commit && final_d;
            if (commit) begin
                wr_addr <= waddr_d;
                wr_data <= act;
            end
        end
    end

    // Status flags registered from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == RUN) || (state_nx == DRAIN);
            done <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_neuron_mac_writer.sv
// Directed bench for neuron_mac_writer: hand-computed
// vectors for single, negative, saturating, chained and aborted neurons.
module tb_neuron_mac_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       neuron_finished = 1'b0;
    logic       finished = 1'b0;
    logic [7:0] neuro_write_addr = '0;
    logic [7:0] weight_data = '0;
    logic [7:0] neuro_data = '0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int last_cyc = 0;

    int wa[$];
    int wd[$];
    int wc[$];
    int dc[$];

    logic [7:0] it_w[8];
    logic [7:0] it_x[8];
    logic [7:0] it_a[8];
    logic       it_nf[8];
    logic       it_fin[8];

    neuron_mac_writer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .neuron_finished  (neuron_finished),
        .finished         (finished),
        .neuro_write_addr (neuro_write_addr),
        .weight_data      (weight_data),
        .neuro_data       (neuro_data),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
        end
        if (done) dc.push_back(cyc);
    end

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        dc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_item(input int i, input logic [7:0] w,
                            input logic [7:0] x, input logic [7:0] a,
                            input logic nf, input logic fin);
        it_w[i]   = w;
        it_x[i]   = x;
        it_a[i]   = a;
        it_nf[i]  = nf;
        it_fin[i] = fin;
    endtask

    // Address flags in cycle i, matching read data one cycle later
    task automatic feed(input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                neuron_finished  = it_nf[i];
                finished         = it_fin[i];
                neuro_write_addr = it_a[i];
                if (i == n - 1) last_cyc = cyc;
            end else begin
                neuron_finished  = 1'b0;
                finished         = 1'b0;
                neuro_write_addr = '0;
            end
            if (i > 0) begin
                weight_data = it_w[i-1];
                neuro_data  = it_x[i-1];
            end else begin
                weight_data = '0;
                neuro_data  = '0;
            end
            @(posedge clk); #1;
        end
        weight_data = '0;
        neuro_data  = '0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single neuron: 0x200+0x100+0x80 = 0x380 -> 0x38
        clear_log();
        set_item(0, 8'h10, 8'h20, 8'h40, 1'b0, 1'b0);
        set_item(1, 8'h10, 8'h10, 8'h40, 1'b0, 1'b0);
        set_item(2, 8'h10, 8'h08, 8'h40, 1'b1, 1'b1);
        pulse_start();
        @(negedge clk);
        chk("run_busy", int'(busy), 1);
        @(posedge clk); #1;
        start = 1'b0;
        feed(3);
        settle();
        chk("single_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("single_addr", wa[0], 'h40);
            chk("single_data", wd[0], 'h38);
            chk("single_lat", wc[0] - last_cyc, 2);
        end
        chk("single_ndone", dc.size(), 1);
        if (dc.size() == 1 && wc.size() == 1)
            chk("single_done_lat", dc[0] - wc[0], 1);
        chk("single_idle_busy", int'(busy), 0);

        // Negative product clamps to zero
        clear_log();
        set_item(0, 8'hF0, 8'h20, 8'h43, 1'b1, 1'b1);
        pulse_start();
        feed(1);
        settle();
        chk("neg_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("neg_addr", wa[0], 'h43);
            chk("neg_data", wd[0], 'h00);
        end

        // Four 0x7F*0x7F products saturate to 0x7F
        clear_log();
        for (int i = 0; i < 4; i++)
            set_item(i, 8'h7F, 8'h7F, 8'h44, i == 3, i == 3);
        pulse_start();
        feed(4);
        settle();
        chk("sat_nwr", wa.size(), 1);
        if (wa.size() == 1) chk("sat_data", wd[0], 'h7F);

        // Back-to-back neurons; final one flagged by finished alone
        clear_log();
        set_item(0, 8'h10, 8'h10, 8'h41, 1'b0, 1'b0);
        set_item(1, 8'h10, 8'h10, 8'h41, 1'b1, 1'b0);
        set_item(2, 8'h10, 8'h20, 8'h42, 1'b0, 1'b0);
        set_item(3, 8'h10, 8'h20, 8'h42, 1'b0, 1'b1);
        pulse_start();
        feed(4);
        settle();
        chk("b2b_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("b2b_addr0", wa[0], 'h41);
            chk("b2b_data0", wd[0], 'h20);
            chk("b2b_addr1", wa[1], 'h42);
            chk("b2b_data1", wd[1], 'h40);
            chk("b2b_gap", wc[1] - wc[0], 2);
        end
        chk("b2b_ndone", dc.size(), 1);

        // Abort partway through a neuron, then a full neuron
        clear_log();
        set_item(0, 8'h7F, 8'h7F, 8'h50, 1'b0, 1'b0);
        set_item(1, 8'h7F, 8'h7F, 8'h50, 1'b0, 1'b0);
        pulse_start();
        feed(2);
        pulse_start();
        set_item(0, 8'h10, 8'h20, 8'h40, 1'b0, 1'b0);
        set_item(1, 8'h10, 8'h10, 8'h40, 1'b0, 1'b0);
        set_item(2, 8'h10, 8'h08, 8'h40, 1'b1, 1'b1);
        feed(3);
        settle();
        chk("abort_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("abort_addr", wa[0], 'h40);
            chk("abort_data", wd[0], 'h38);
        end
        chk("abort_ndone", dc.size(), 1);

        // Reset mid-neuron discards the partial sum without a write
        clear_log();
        pulse_start();
        neuron_finished  = 1'b1;
        finished         = 1'b1;
        neuro_write_addr = 8'h60;
        @(posedge clk); #1;
        neuron_finished  = 1'b0;
        finished         = 1'b0;
        weight_data      = 8'h10;
        neuro_data       = 8'h10;
        reset            = 1'b0;
        @(posedge clk); #1;
        weight_data = '0;
        neuro_data  = '0;
        reset       = 1'b1;
        settle();
        chk("rstmid_nwr", wa.size(), 0);
        chk("rstmid_ndone", dc.size(), 0);
        chk("rstmid_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/neuron_mac_writer.md
NEURON_MAC_WRITER -- requirements
Module: neuron_mac_writer

Interface
REQ-001 Parameter DATA_W, default 8, sets the width of weights, activations and written results (signed Q4.4).
REQ-002 Parameter ACC_W, default 24, sets the width of the signed accumulator (Q16.8).
REQ-003 Parameter FRAC, default 4, sets the number of fractional bits of DATA_W values.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; the address stream begins the following cycle.
REQ-007 neuron_finished  input  1  marks the last input address of the current neuron.
REQ-008 finished  input  1  marks the last input address of the last neuron in the layer.
REQ-009 neuro_write_addr  input  8  destination address for the current neuron's result.
REQ-010 weight_data  input  DATA_W  weight memory read data, valid 1 cycle after its address.
REQ-011 neuro_data  input  DATA_W  neuron memory read data, valid 1 cycle after its address.
REQ-012 wr_en  output  1  one-cycle write strobe to neuron memory.
REQ-013 wr_addr  output  8  write address, qualified by wr_en.
REQ-014 wr_data  output  DATA_W  activated result, qualified by wr_en.
REQ-015 busy  output  1  high in states RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse after the layer's final write.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN on start; RUN->DRAIN when finished is sampled high; DRAIN->DONE after the final write issues; DONE->IDLE unconditionally after one cycle.
REQ-019 In RUN, the block SHALL register neuron_finished, finished and neuro_write_addr into a one-stage delay (last_d, final_d, waddr_d), aligning them with the memory data.
REQ-020 Each data-valid cycle, acc_next SHALL equal acc plus the sign-extended full-precision product weight_data*neuro_data (2*DATA_W bits).
REQ-021 When last_d is high: acc clears to 0; wr_en asserts next cycle with wr_addr=waddr_d and wr_data=act(acc_next); latency = 2 cycles from neuron_finished sampled high to wr_en.
REQ-022 act(x): arithmetic shift right by FRAC, truncate, clamp to [0, 2^(DATA_W-1)-1] (ReLU plus positive saturation).
REQ-023 finished high without neuron_finished SHALL be treated as both flags high.
REQ-024 start in RUN or DRAIN SHALL abort: pipeline and acc cleared, no write for the partial neuron, FSM stays in RUN.
REQ-025 Back-to-back neurons SHALL be processed without bubbles; the first product of neuron n+1 accumulates from 0.
REQ-026 Inputs other than start SHALL be ignored in IDLE and DONE.

Reset
REQ-027 When reset is low: FSM=IDLE; acc, delay registers, wr_en, wr_addr, wr_data, busy and done all 0; no write issues during or on exit from reset.
REQ-028 Reset mid-operation SHALL discard all partial sums with no write.

Structure
REQ-029 Package nn_pkg SHALL hold DATA_W, ACC_W and FRAC defaults and the FSM state enumeration.
REQ-030 The activation SHALL be a combinational sub-module relu_sat, reused by later layers.

Verification
REQ-031 Reset: hold reset low 3 cycles -> all outputs 0, FSM=IDLE.
REQ-032 Single neuron, weights 0x10,0x10,0x10, inputs 0x20,0x10,0x08, write addr 0x40 -> one wr_en, wr_addr=0x40, wr_data=0x38, done one cycle later.
REQ-033 Negative: weight 0xF0, input 0x20 -> wr_data=0x00.
REQ-034 Saturation: four products 0x7F*0x7F -> wr_data=0x7F.
REQ-035 Two back-to-back 2-input neurons, all weights 0x10, inputs 0x10/0x10 then 0x20/0x20, addrs 0x41/0x42 -> writes 0x20@0x41 then 0x40@0x42, two cycles apart, single done.
REQ-036 Abort: start mid-neuron -> no wr_en for the partial neuron; the following neuron's result is correct.
